read_src_fsm: RTL and testbench
===============================

Name: read_src_fsm

Overview:
Upstream stage of the DMA datapath. On a descriptor go, issues AXI read bursts to the source memory and pushes returned beats into the DMA data FIFO. The destination-write stage drains that FIFO. Splits a transfer into bursts of at most MAX_BURST beats, never crossing a 4 KB boundary, with one burst in flight; reports busy/error status to the CSR block.

Parameters:
DATA_W, 512, data beat width in bits; BYTES_PER_BEAT = DATA_W/8.
MAX_BURST, 16, max beats per AR burst (power of two, 1..256).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
descriptor  in  dma_pkg::t_dma_descriptor  src_addr (beat-aligned), length (beats), descriptor_control.go
csr_control  in  dma_pkg::t_dma_csr_control  reset_dispatcher clears ERROR
rd_src_status  out  dma_pkg::t_dma_csr_status  busy, stopped_on_error
rd_fsm_done  out  1  one-cycle pulse when all beats are written to FIFO
src_mem  ofs_plat_axi_mem_if.to_sink  AXI master to source memory
wr_fifo_if  dma_fifo_if.wr_in  wr_en, wr_data[DATA_W], almost_full

Behaviour:
- Reset (async, reset_n low) state: arvalid=0, rd_fsm_done=0, wr_en=0, busy=0, stopped_on_error=0, counters 0, state IDLE.
- Write channels are tied off: awvalid=0, wvalid=0, bready=1.
- AR fields: burst=INCR (1), size=log2(BYTES_PER_BEAT), id=0.
- Burst length:
  - burst_beats = min(remaining, MAX_BURST, (4096 - cur_addr[11:0]) / BYTES_PER_BEAT).
  - ar.len = burst_beats - 1.
  - Counters: remaining is 32 bits; the beat counter is 9 bits.
- IDLE:
  - go=1 and length=0 → pulse rd_fsm_done next cycle, stay IDLE, no AR.
  - go=1 and length>0 → latch cur_addr=src_addr, remaining=length, set busy=1, go to ADDR_SETUP.
- ADDR_SETUP:
  - arvalid=1; ar.addr/len stay stable until arready.
  - On arvalid&arready → arvalid=0, load beat counter=burst_beats, go to RD_SRC_WR_FIFO.
- RD_SRC_WR_FIFO:
  - rready = !almost_full (combinational).
  - Each rvalid&rready beat:
    - wr_en=1 and wr_data=r.data, registered, one cycle after the handshake.
    - Decrement the beat counter.
  - On the last beat: cur_addr += burst_beats*BYTES_PER_BEAT and remaining -= burst_beats.
  - Last beat with remaining now 0 → DONE; otherwise → ADDR_SETUP (next AR issued the following cycle).
  - almost_full must assert with at least 2 free entries; no beat is ever dropped.
- DONE: one-cycle rd_fsm_done=1, busy=0, go to IDLE. A go still high re-arms on the next IDLE cycle.
- ERROR entry: any beat with r.resp = SLVERR or DECERR, or an rlast/beat-count mismatch (rlast early, or missing on the final counted beat).
- ERROR behaviour:
  - stopped_on_error=1, busy=0.
  - rready=1 drains and discards the rest of the burst; no FIFO writes.
  - reset_dispatcher=1 → clear stopped_on_error and go to IDLE. reset_dispatcher has no effect in other states.
- Simultaneous error and rlast on one beat → ERROR wins; that beat is not written.
- reset_n asserted mid-burst → immediate return to reset values; the outstanding AXI burst is abandoned (the system resets memory side with it).

Optional Feature:
RD_SRC_STALL_CNT_EN defined:
- Adds output rd_stall_cnt [31:0].
- Counts cycles with rvalid=1 and rready=0.
- Clears on go acceptance in IDLE, saturates at all-ones, resets to 0.

RD_SRC_STALL_CNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
dma_pkg holds:
- AXI resp enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
- AXI_BURST_INCR constant
- PAGE_BYTES=4096
- the descriptor/status/control structs

Sub-module dma_burst_calc (combinational): cur_addr, remaining → burst_beats, using the DATA_W and MAX_BURST parameters.

Test Plan:
1. src_addr=0x1000, length=40, MAX_BURST=16 → three ARs at 0x1000/0x1400/0x1800 with len 15/15/7; 40 wr_en pulses in order; one rd_fsm_done.
2. src_addr=0x1F80, length=4 → AR 0x1F80 len=1, then AR 0x2000 len=1; 4 FIFO writes.
3. almost_full held high 10 cycles mid-burst while rvalid=1 → rready=0 for those cycles; all 16 beats written once, data order intact; stall counter=10 with RD_SRC_STALL_CNT_EN.
4. SLVERR on beat 3 of 16 → 2 FIFO writes only, stopped_on_error=1, rest of burst drained; reset_dispatcher pulse → IDLE, status cleared.
5. length=0 with go → no AR, rd_fsm_done pulses once next cycle.
6. reset_n low during beat 5 → all outputs at reset values immediately; a new go after release runs a clean transfer.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA types: AXI response codes, descriptor/CSR structs and the
// read-source FSM state encoding.
package dma_pkg;

    localparam int ADDR_W = 64;
    localparam int PAGE_BYTES = 4096;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } t_axi_resp;

    typedef struct packed {
        logic go;
    } t_dma_descriptor_control;

    typedef struct packed {
        logic [ADDR_W-1:0]       src_addr;
        logic [31:0]             length;
        t_dma_descriptor_control descriptor_control;
    } t_dma_descriptor;

    typedef struct packed {
        logic reset_dispatcher;
    } t_dma_csr_control;

    typedef struct packed {
        logic busy;
        logic stopped_on_error;
    } t_dma_csr_status;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SETUP,
        RD_SRC_WR_FIFO,
        DONE,
        ERROR
    } t_rd_src_state;

endpackage

// File: rtl/read_src_fsm_if.sv
// Source-memory AXI read interface (write channels reduced to tie-off
// signals) and the DMA data FIFO write port.
interface ofs_plat_axi_mem_if
    import dma_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    t_axi_resp         rresp;
    logic              rlast;

    logic              awvalid;
    logic              wvalid;
    logic              bready;

    modport to_sink (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
               awvalid, wvalid, bready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport to_source (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
               awvalid, wvalid, bready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

interface dma_fifo_if #(
    parameter int DATA_W = 512
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              almost_full;

    modport wr_in  (output wr_en, wr_data, input almost_full);
    modport wr_out (input wr_en, wr_data, output almost_full);
endinterface

// File: rtl/read_src_fsm_burst_calc.sv
// Burst sizing: the largest burst that fits the remaining beats, MAX_BURST
// and the bytes left before the next 4 KB page boundary.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int MAX_BURST = 16
) (
    input  logic [11:0] page_offset,
    input  logic [31:0] remaining,
    output logic [8:0]  burst_beats
);
    localparam int BEAT_SHIFT = $clog2(DATA_W / 8);

    logic [12:0] page_bytes_left;
    logic [12:0] page_beats;
    logic [12:0] cap;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        page_bytes_left = 13'(PAGE_BYTES) - {1'b0, page_offset};
        page_beats      = page_bytes_left >> BEAT_SHIFT;
        cap             = 13'(MAX_BURST);
        if (page_beats < cap) begin
            cap = page_beats;
        end
        burst_beats = cap[8:0];
        if (remaining < {19'd0, cap}) begin
            burst_beats = remaining[8:0];
        end
    end
endmodule

// File: rtl/read_src_fsm.sv
// DMA read-source stage: splits a descriptor into page-safe AXI read bursts
// and pushes returned beats into the data FIFO. Macro RD_SRC_STALL_CNT_EN adds rd_stall_cnt.
module read_src_fsm
    import dma_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  t_dma_descriptor            descriptor,
    input  t_dma_csr_control           csr_control,
    output t_dma_csr_status            rd_src_status,
    output logic                       rd_fsm_done,
    ofs_plat_axi_mem_if.to_sink        src_mem,
    dma_fifo_if.wr_in                  wr_fifo_if
`ifdef RD_SRC_STALL_CNT_EN
    ,
    output logic [31:0]                rd_stall_cnt
`endif
);
    localparam int BEAT_SHIFT = $clog2(DATA_W / 8);

    t_rd_src_state     state;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       remaining;
    logic [8:0]        beat_cnt;
    logic [8:0]        burst_beats;
    logic              arvalid_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              done_q;
    logic              busy_q;
    logic              err_q;

    logic rready;
    logic beat_fire;
    logic last_counted;
    logic beat_err;

    dma_burst_calc #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .page_offset (cur_addr[11:0]),
        .remaining   (remaining),
        .burst_beats (burst_beats)
    );

    // ERROR keeps rready high so the abandoned burst drains without backpressure.
    assign rready       = (state == RD_SRC_WR_FIFO) ? !wr_fifo_if.almost_full : (state == ERROR);
    assign beat_fire    = src_mem.rvalid && rready;
    assign last_counted = (beat_cnt == 9'd1);
    assign beat_err     = (src_mem.rresp == SLVERR) || (src_mem.rresp == DECERR) ||
                          (src_mem.rlast != last_counted);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            arvalid_q <= 1'b0;
            wr_en_q   <= 1'b0;
            // NOTE: wr_data is qualified by wr_en, but one reset block keeps the FSM in a single process.
            wr_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (descriptor.descriptor_control.go) begin
                        if (descriptor.length == 32'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            cur_addr  <= descriptor.src_addr;
                            remaining <= descriptor.length;
                            busy_q    <= 1'b1;
                            arvalid_q <= 1'b1;
                            state     <= ADDR_SETUP;
                        end
                    end
                end
                ADDR_SETUP: begin
                    if (src_mem.arready) begin
                        arvalid_q <= 1'b0;
                        beat_cnt  <= burst_beats;
                        state     <= RD_SRC_WR_FIFO;
                    end
                end
                RD_SRC_WR_FIFO: begin
                    if (beat_fire) begin
                        if (beat_err) begin
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= ERROR;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= src_mem.rdata;
                            beat_cnt  <= beat_cnt - 9'd1;
                            if (last_counted) begin
                                cur_addr  <= cur_addr + (ADDR_W'(burst_beats) << BEAT_SHIFT);
                                remaining <= remaining - 32'(burst_beats);
                                if (remaining == 32'(burst_beats)) begin
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                    state  <= DONE;
                                end else begin
                                    arvalid_q <= 1'b1;
                                    state     <= ADDR_SETUP;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERROR: begin
                    if (csr_control.reset_dispatcher) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RD_SRC_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_stall_cnt <= '0;
        end else if (state == IDLE && descriptor.descriptor_control.go) begin
            rd_stall_cnt <= '0;
        end else if (src_mem.rvalid && !rready && rd_stall_cnt != '1) begin
            rd_stall_cnt <= rd_stall_cnt + 32'd1;
        end
    end
`endif

    assign src_mem.arvalid = arvalid_q;
    assign src_mem.araddr  = cur_addr;
    assign src_mem.arlen   = 8'(burst_beats - 9'd1);
    assign src_mem.arsize  = 3'(BEAT_SHIFT);
    assign src_mem.arburst = AXI_BURST_INCR;
    assign src_mem.arid    = '0;
    assign src_mem.rready  = rready;
    assign src_mem.awvalid = 1'b0;
    assign src_mem.wvalid  = 1'b0;
    assign src_mem.bready  = 1'b1;

    assign wr_fifo_if.wr_en   = wr_en_q;
    assign wr_fifo_if.wr_data = wr_data_q;

    assign rd_fsm_done                    = done_q;
    assign rd_src_status.busy             = busy_q;
    assign rd_src_status.stopped_on_error = err_q;
endmodule

// File: tb/tb_read_src_fsm.sv
// Randomised bench for read_src_fsm: an AXI read slave, a transfer-level
// expectation model (burst list + beat data queue) and one per-cycle monitor.
`timescale 1ns/1ps
module tb_read_src_fsm;
    import dma_pkg::*;

    localparam int DATA_W    = 512;
    localparam int MAX_BURST = 16;
    localparam int BPB       = DATA_W / 8;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    t_dma_descriptor  descriptor;
    t_dma_csr_control csr_control;
    t_dma_csr_status  rd_src_status;
    logic             rd_fsm_done;
`ifdef RD_SRC_STALL_CNT_EN
    logic [31:0]      rd_stall_cnt;
`endif

    ofs_plat_axi_mem_if #(.DATA_W(DATA_W)) src_mem ();
    dma_fifo_if #(.DATA_W(DATA_W)) wr_fifo ();

    read_src_fsm #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .descriptor    (descriptor),
        .csr_control   (csr_control),
        .rd_src_status (rd_src_status),
        .rd_fsm_done   (rd_fsm_done),
        .src_mem       (src_mem),
        .wr_fifo_if    (wr_fifo)
`ifdef RD_SRC_STALL_CNT_EN
        ,
        .rd_stall_cnt  (rd_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    ar_t               exp_ar_q[$];
    ar_t               ar_log[$];
    logic [DATA_W-1:0] exp_wr_q[$];
    logic [31:0]       salt = 32'h0;
    int                done_cnt = 0;
    int                wr_cnt = 0;
    int                stall_seen = 0;
    int                beats_fired = 0;

    int gap_pct = 30;
    int arr_pct = 60;
    bit af_random = 1'b0;
    bit af_force = 1'b0;
    bit inject_err = 1'b0;
    int err_beat = 0;
    bit pend = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input logic [63:0] addr);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) begin
            d[i*32 +: 32] = addr[31:0] ^ (32'h9E3779B9 * 32'(i + 1)) ^ salt;
        end
        return d;
    endfunction

    // Expected burst list and beat stream derived directly from the transfer rules.
    task automatic build_model(input logic [63:0] addr, input int len);
        logic [63:0] a;
        int rem, page, n;
        ar_t e;
        a = addr;
        rem = len;
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / BPB;
            n = rem;
            if (n > MAX_BURST) n = MAX_BURST;
            if (n > page) n = page;
            e.addr = a;
            e.len = 8'(n - 1);
            exp_ar_q.push_back(e);
            for (int k = 0; k < n; k++) exp_wr_q.push_back(beat_data(a + 64'(k * BPB)));
            a += 64'(n * BPB);
            rem -= n;
        end
    endtask

    // AXI read slave: one burst at a time, random arready and rvalid gaps.
    initial begin : slave
        bit ar_fire, r_fire, hold;
        logic [63:0] ar_addr_s, pend_addr;
        logic [7:0] ar_len_s;
        int pend_len, beat_idx;
        src_mem.arready = 1'b0;
        src_mem.rvalid  = 1'b0;
        src_mem.rdata   = '0;
        src_mem.rresp   = OKAY;
        src_mem.rlast   = 1'b0;
        pend_addr = '0;
        pend_len = 0;
        beat_idx = 0;
        forever begin
            @(negedge clk);
            ar_fire   = reset_n && src_mem.arvalid && src_mem.arready;
            r_fire    = reset_n && src_mem.rvalid && src_mem.rready;
            ar_addr_s = src_mem.araddr;
            ar_len_s  = src_mem.arlen;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                pend = 1'b0;
                src_mem.rvalid  = 1'b0;
                src_mem.rlast   = 1'b0;
                src_mem.arready = 1'b0;
                continue;
            end
            if (r_fire) begin
                beats_fired++;
                beat_idx++;
                if (beat_idx == pend_len) pend = 1'b0;
            end
            if (ar_fire) begin
                check("one_burst_in_flight", DATA_W'(pend), '0);
                pend = 1'b1;
                pend_addr = ar_addr_s;
                pend_len = int'(ar_len_s) + 1;
                beat_idx = 0;
            end
            hold = src_mem.rvalid && !r_fire;
            if (pend && (hold || int'($urandom_range(99)) >= gap_pct)) begin
                src_mem.rvalid = 1'b1;
                src_mem.rdata  = beat_data(pend_addr + 64'(beat_idx * BPB));
                src_mem.rlast  = (beat_idx == pend_len - 1);
                src_mem.rresp  = (inject_err && beat_idx == err_beat) ? SLVERR : OKAY;
            end else begin
                src_mem.rvalid = 1'b0;
                src_mem.rlast  = 1'b0;
                src_mem.rresp  = OKAY;
            end
            src_mem.arready = (int'($urandom_range(99)) < arr_pct);
        end
    end

    initial begin : af_driver
        wr_fifo.almost_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wr_fifo.almost_full = af_force || (af_random && $urandom_range(99) < 25);
        end
    end

    // Per-cycle compare of every DUT output against the model.
    initial begin : monitor
        ar_t got, e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("awvalid_tied", DATA_W'(src_mem.awvalid), '0);
                check("wvalid_tied", DATA_W'(src_mem.wvalid), '0);
                check("bready_tied", DATA_W'(src_mem.bready), DATA_W'(1));
                if (src_mem.arvalid) begin
                    check("arsize", DATA_W'(src_mem.arsize), DATA_W'(6));
                    check("arburst", DATA_W'(src_mem.arburst), DATA_W'(1));
                    check("arid", DATA_W'(src_mem.arid), '0);
                end
                if (src_mem.arvalid && src_mem.arready) begin
                    got.addr = src_mem.araddr;
                    got.len  = src_mem.arlen;
                    ar_log.push_back(got);
                    if (exp_ar_q.size() == 0) begin
                        check("unexpected_ar", DATA_W'(1), '0);
                    end else begin
                        e = exp_ar_q.pop_front();
                        check("ar_addr", DATA_W'(got.addr), DATA_W'(e.addr));
                        check("ar_len", DATA_W'(got.len), DATA_W'(e.len));
                    end
                end
                if (wr_fifo.wr_en) begin
                    wr_cnt++;
                    if (exp_wr_q.size() == 0) check("unexpected_write", DATA_W'(1), '0);
                    else check("wr_data", wr_fifo.wr_data, exp_wr_q.pop_front());
                end
                if (wr_fifo.almost_full) check("rready_blocked", DATA_W'(src_mem.rready), '0);
                else if (pend) check("rready_open", DATA_W'(src_mem.rready), DATA_W'(1));
                if (src_mem.rvalid && !src_mem.rready) stall_seen++;
                if (rd_fsm_done) begin
                    done_cnt++;
                    check("done_after_all_writes", DATA_W'(exp_wr_q.size()), '0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [63:0] addr, input int len);
        salt = $urandom;
        build_model(addr, len);
        descriptor.src_addr = addr;
        descriptor.length = 32'(len);
        descriptor.descriptor_control.go = 1'b1;
        tick();
        descriptor.descriptor_control.go = 1'b0;
        check("busy_after_go", DATA_W'(rd_src_status.busy), DATA_W'(len > 0));
        check("done_after_go", DATA_W'(rd_fsm_done), DATA_W'(len == 0));
    endtask

    task automatic wait_done(input int d0, input int max_cycles);
        for (int c = 0; c < max_cycles && done_cnt == d0; c++) tick();
        check("done_within_budget", DATA_W'(done_cnt != d0), DATA_W'(1));
        repeat (3) tick();
        check("done_pulse_count", DATA_W'(done_cnt - d0), DATA_W'(1));
        check("model_ar_drained", DATA_W'(exp_ar_q.size()), '0);
        check("model_wr_drained", DATA_W'(exp_wr_q.size()), '0);
        check("busy_after_done", DATA_W'(rd_src_status.busy), '0);
    endtask

    task automatic run_xfer(input logic [63:0] addr, input int len);
        int d0;
        d0 = done_cnt;
        start_xfer(addr, len);
        wait_done(d0, 60 + len * 12);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arvalid"}, DATA_W'(src_mem.arvalid), '0);
        check({tag, "_wr_en"}, DATA_W'(wr_fifo.wr_en), '0);
        check({tag, "_done"}, DATA_W'(rd_fsm_done), '0);
        check({tag, "_busy"}, DATA_W'(rd_src_status.busy), '0);
        check({tag, "_stopped"}, DATA_W'(rd_src_status.stopped_on_error), '0);
        check({tag, "_rready"}, DATA_W'(src_mem.rready), '0);
`ifdef RD_SRC_STALL_CNT_EN
        check({tag, "_stall_cnt"}, DATA_W'(rd_stall_cnt), '0);
`endif
    endtask

    initial begin : main
        logic [63:0] t1_addr [3];
        int d0, w0, s0, b0;
        t1_addr = '{64'h1000, 64'h1400, 64'h1800};
        descriptor  = '0;
        csr_control = '0;
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Multi-burst transfer split at MAX_BURST.
        af_random = 1'b1;
        ar_log.delete();
        w0 = wr_cnt;
        run_xfer(64'h1000, 40);
        check("t1_ar_count", DATA_W'(ar_log.size()), DATA_W'(3));
        for (int i = 0; i < 3 && i < ar_log.size(); i++) begin
            check("t1_ar_addr", DATA_W'(ar_log[i].addr), DATA_W'(t1_addr[i]));
            check("t1_ar_len", DATA_W'(ar_log[i].len), DATA_W'((i == 2) ? 7 : 15));
        end
        check("t1_writes", DATA_W'(wr_cnt - w0), DATA_W'(40));

        // 4 KB page crossing.
        ar_log.delete();
        w0 = wr_cnt;
        run_xfer(64'h1F80, 4);
        check("t2_ar_count", DATA_W'(ar_log.size()), DATA_W'(2));
        if (ar_log.size() == 2) begin
            check("t2_ar0_addr", DATA_W'(ar_log[0].addr), DATA_W'(64'h1F80));
            check("t2_ar0_len", DATA_W'(ar_log[0].len), DATA_W'(1));
            check("t2_ar1_addr", DATA_W'(ar_log[1].addr), DATA_W'(64'h2000));
            check("t2_ar1_len", DATA_W'(ar_log[1].len), DATA_W'(1));
        end
        check("t2_writes", DATA_W'(wr_cnt - w0), DATA_W'(4));

        // almost_full held for 10 cycles mid-burst.
        af_random = 1'b0;
        gap_pct = 0;
        d0 = done_cnt;
        w0 = wr_cnt;
        s0 = stall_seen;
        start_xfer(64'h3000, 16);
        for (int c = 0; c < 200 && wr_cnt - w0 < 5; c++) tick();
        check("t3_reached_beat5", DATA_W'(wr_cnt - w0 >= 5), DATA_W'(1));
        af_force = 1'b1;
        repeat (10) tick();
        af_force = 1'b0;
        wait_done(d0, 300);
        check("t3_stall_cycles", DATA_W'(stall_seen - s0), DATA_W'(10));
        check("t3_writes", DATA_W'(wr_cnt - w0), DATA_W'(16));
`ifdef RD_SRC_STALL_CNT_EN
        check("t3_stall_cnt", DATA_W'(rd_stall_cnt), DATA_W'(10));
`endif

        // SLVERR on beat 3 of 16.
        gap_pct = 30;
        inject_err = 1'b1;
        err_beat = 2;
        d0 = done_cnt;
        w0 = wr_cnt;
        b0 = beats_fired;
        start_xfer(64'h5000, 16);
        while (exp_wr_q.size() > 2) void'(exp_wr_q.pop_back());
        for (int c = 0; c < 400 && beats_fired - b0 < 16; c++) tick();
        check("t4_burst_drained", DATA_W'(beats_fired - b0), DATA_W'(16));
        tick();
        check("t4_writes", DATA_W'(wr_cnt - w0), DATA_W'(2));
        check("t4_stopped", DATA_W'(rd_src_status.stopped_on_error), DATA_W'(1));
        check("t4_busy", DATA_W'(rd_src_status.busy), '0);
        check("t4_drain_rready", DATA_W'(src_mem.rready), DATA_W'(1));
        check("t4_no_done", DATA_W'(done_cnt - d0), '0);
        inject_err = 1'b0;
        csr_control.reset_dispatcher = 1'b1;
        tick();
        csr_control.reset_dispatcher = 1'b0;
        tick();
        check("t4_stopped_cleared", DATA_W'(rd_src_status.stopped_on_error), '0);
        check("t4_idle_rready", DATA_W'(src_mem.rready), '0);

        // Zero-length descriptor.
        ar_log.delete();
        d0 = done_cnt;
        start_xfer(64'h4000, 0);
        repeat (4) tick();
        check("t5_done_count", DATA_W'(done_cnt - d0), DATA_W'(1));
        check("t5_no_ar", DATA_W'(ar_log.size()), '0);

        // Reset during beat 5, then a clean page-crossing transfer.
        gap_pct = 0;
        w0 = wr_cnt;
        start_xfer(64'h6000, 16);
        for (int c = 0; c < 200 && wr_cnt - w0 < 4; c++) tick();
        check("t6_reached_beat5", DATA_W'(wr_cnt - w0), DATA_W'(4));
        reset_n = 1'b0;
        #1;
        check_reset_values("t6_midreset");
        exp_ar_q.delete();
        exp_wr_q.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        gap_pct = 30;
        af_random = 1'b1;
        ar_log.delete();
        w0 = wr_cnt;
        run_xfer(64'h7FC0, 20);
        check("t6_ar_count", DATA_W'(ar_log.size()), DATA_W'(3));
        if (ar_log.size() > 0) begin
            check("t6_ar0_addr", DATA_W'(ar_log[0].addr), DATA_W'(64'h7FC0));
            check("t6_ar0_len", DATA_W'(ar_log[0].len), '0);
        end
        check("t6_writes", DATA_W'(wr_cnt - w0), DATA_W'(20));

        // Random transfers around page boundaries.
        for (int t = 0; t < 8; t++) begin
            logic [63:0] a;
            a = 64'($urandom_range(15)) * 64'd4096 + 64'($urandom_range(63)) * 64'(BPB);
            run_xfer(a, int'($urandom_range(1, 70)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
